// File: rtl/ddr_to_rgb_pkg.sv
// Shared types and constants for the DDR-to-pixel read path (ddr_to_rgb).
package ddr_to_rgb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_SPACE,
      ST_CMD,
      ST_DATA,
      ST_DONE
   } state_e;

   localparam logic [2:0]  MCB_CMD_READ   = 3'b001;
   localparam int unsigned FREE_MARGIN    = 4;
   localparam int unsigned BYTES_PER_WORD = 4;
   // Burst length field width: holds 1..64 words.
   localparam int unsigned LEN_W          = 7;

endpackage

// File: rtl/mcb_burst_planner.sv
// MCB burst planner: tracks frame address/remaining words, sizes the next burst
// and decides whether the downstream FIFO has room for it.
module mcb_burst_planner
   import ddr_to_rgb_pkg::*;
#(
   parameter int unsigned BURST_LEN        = 32,
   parameter int unsigned FIFO_DEPTH       = 4096,
   parameter int unsigned DATA_COUNT_WIDTH = $clog2(FIFO_DEPTH) + 1,
   parameter int unsigned FRAME_BASE_ADDR  = 0,
   parameter int unsigned FRAME_PIXELS     = 786432,
   parameter int unsigned REM_W            = $clog2(FRAME_PIXELS + 1)
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        load_i,
   input  logic                        advance_i,
   input  logic [DATA_COUNT_WIDTH-1:0] fifo_count_i,
   output logic [29:0]                 addr_o,
   output logic [LEN_W-1:0]            len_o,
   output logic                        space_ok_o,
   output logic                        last_o
);

   logic [29:0]      addr_q, addr_d;
   logic [REM_W-1:0] rem_q, rem_d;

   always_comb begin
      if (32'(rem_q) >= BURST_LEN) len_o = LEN_W'(BURST_LEN);
      else                         len_o = LEN_W'(rem_q);
   end

   // Summed form avoids underflow if the reported count ever exceeds the depth.
   assign space_ok_o = (32'(fifo_count_i) + 32'(len_o) + FREE_MARGIN) <= FIFO_DEPTH;
   assign last_o     = (rem_q == REM_W'(len_o));
   assign addr_o     = addr_q;

   always_comb begin
      addr_d = addr_q;
      rem_d  = rem_q;
      if (load_i) begin
         addr_d = 30'(FRAME_BASE_ADDR);
         rem_d  = REM_W'(FRAME_PIXELS);
      end else if (advance_i) begin
         addr_d = addr_q + 30'(32'(len_o) * BYTES_PER_WORD);
         rem_d  = rem_q - REM_W'(len_o);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         addr_q <= '0;
         rem_q  <= '0;
      end else begin
         addr_q <= addr_d;
         rem_q  <= rem_d;
      end
   end

endmodule

// File: rtl/ddr_to_rgb.sv
// Frame fetch from DDR (MCB user port) into the pixel output FIFO.
// Optional status outputs enabled by DDR_TO_RGB_STATUS_EN.
module ddr_to_rgb
   import ddr_to_rgb_pkg::*;
#(
   parameter int unsigned RGB_WIDTH        = 24,
   parameter int unsigned FIFO_DEPTH       = 4096,
   parameter int unsigned DATA_COUNT_WIDTH = $clog2(FIFO_DEPTH) + 1,
   parameter int unsigned BURST_LEN        = 32,
   parameter int unsigned FRAME_BASE_ADDR  = 0,
   parameter int unsigned FRAME_PIXELS     = 786432
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        frame_start,
   output logic                        busy,
   output logic                        frame_done,
   output logic                        cmd_en,
   output logic [2:0]                  cmd_instr,
   output logic [5:0]                  cmd_bl,
   output logic [29:0]                 cmd_byte_addr,
   input  logic                        cmd_full,
   output logic                        rd_en,
   input  logic [31:0]                 rd_data,
   input  logic                        rd_empty,
   output logic [RGB_WIDTH-1:0]        fifo_data_in,
   output logic                        fifo_write_enable,
   input  logic                        fifo_full,
   input  logic [DATA_COUNT_WIDTH-1:0] fifo_wr_data_count
`ifdef DDR_TO_RGB_STATUS_EN
   ,
   output logic                        err_overflow,
   output logic [15:0]                 frame_count,
   output logic [15:0]                 stall_cycles
`endif
);

   state_e               state_q, state_d;
   logic [LEN_W-1:0]     beat_q;
   logic                 done_wait_q;
   logic [RGB_WIDTH-1:0] fifo_data_q;
   logic                 fifo_wr_q;

   logic                 accept, pop, last_pop;
   logic [29:0]          addr;
   logic [LEN_W-1:0]     len;
   logic                 space_ok, last;
   logic                 unused_ok;

   assign unused_ok = ^{rd_data[31:RGB_WIDTH], fifo_full};

   mcb_burst_planner #(
      .BURST_LEN        (BURST_LEN),
      .FIFO_DEPTH       (FIFO_DEPTH),
      .DATA_COUNT_WIDTH (DATA_COUNT_WIDTH),
      .FRAME_BASE_ADDR  (FRAME_BASE_ADDR),
      .FRAME_PIXELS     (FRAME_PIXELS)
   ) u_planner (
      .clk_i        (clk),
      .rst_i        (rst),
      .load_i       (accept),
      .advance_i    (last_pop),
      .fifo_count_i (fifo_wr_data_count),
      .addr_o       (addr),
      .len_o        (len),
      .space_ok_o   (space_ok),
      .last_o       (last)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:       if (frame_start && rd_empty) state_d = ST_WAIT_SPACE;
         ST_WAIT_SPACE: if (!cmd_full && space_ok)   state_d = ST_CMD;
         ST_CMD:        state_d = ST_DATA;
         ST_DATA:       if (last_pop) state_d = last ? ST_DONE : ST_WAIT_SPACE;
         ST_DONE:       if (done_wait_q) state_d = ST_IDLE;
         default:       state_d = ST_IDLE;
      endcase
   end

   // rd_en is held off during reset so no word is popped while the frame aborts.
   always_comb begin
      busy          = 1'b0;
      frame_done    = 1'b0;
      cmd_en        = 1'b0;
      cmd_bl        = '0;
      cmd_byte_addr = '0;
      rd_en         = 1'b0;
      accept        = 1'b0;
      pop           = 1'b0;
      last_pop      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            rd_en  = !rd_empty && !rst;
            accept = frame_start && rd_empty;
         end
         ST_WAIT_SPACE: busy = 1'b1;
         ST_CMD: begin
            busy          = 1'b1;
            cmd_en        = 1'b1;
            cmd_bl        = 6'(len - LEN_W'(1));
            cmd_byte_addr = addr;
         end
         ST_DATA: begin
            busy     = 1'b1;
            rd_en    = !rd_empty && !rst;
            pop      = rd_en;
            last_pop = pop && ((beat_q + LEN_W'(1)) == len);
         end
         ST_DONE: begin
            busy       = 1'b1;
            frame_done = done_wait_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         beat_q      <= '0;
         done_wait_q <= 1'b0;
         fifo_data_q <= '0;
         fifo_wr_q   <= 1'b0;
      end else begin
         if (state_q == ST_CMD) beat_q <= '0;
         else if (pop)          beat_q <= beat_q + LEN_W'(1);
         done_wait_q <= (state_q == ST_DONE) && !done_wait_q;
         fifo_wr_q   <= pop;
         if (pop) fifo_data_q <= rd_data[RGB_WIDTH-1:0];
      end
   end

   assign cmd_instr         = MCB_CMD_READ;
   assign fifo_data_in      = fifo_data_q;
   assign fifo_write_enable = fifo_wr_q;

`ifdef DDR_TO_RGB_STATUS_EN
   logic        err_q;
   logic [15:0] frame_cnt_q;
   logic [15:0] stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q       <= 1'b0;
         frame_cnt_q <= '0;
         stall_q     <= '0;
      end else begin
         if (fifo_wr_q && fifo_full) err_q <= 1'b1;
         if (frame_done) frame_cnt_q <= frame_cnt_q + 16'd1;
         if (accept) stall_q <= '0;
         else if (state_q == ST_WAIT_SPACE && stall_q != '1) stall_q <= stall_q + 16'd1;
      end
   end

   assign err_overflow = err_q;
   assign frame_count  = frame_cnt_q;
   assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_ddr_to_rgb.sv
// Directed bench for ddr_to_rgb with a small MCB read-port model (80-pixel frame).
module tb_ddr_to_rgb;

   logic        clk = 1'b0;
   logic        rst, frame_start, cmd_full, fifo_full;
   logic [12:0] fifo_wr_data_count;
   logic        busy, frame_done, cmd_en, rd_en, rd_empty, fifo_write_enable;
   logic [2:0]  cmd_instr;
   logic [5:0]  cmd_bl;
   logic [29:0] cmd_byte_addr;
   logic [31:0] rd_data;
   logic [23:0] fifo_data_in;
`ifdef DDR_TO_RGB_STATUS_EN
   logic        err_overflow;
   logic [15:0] frame_count, stall_cycles;
`endif

   always #5 clk = ~clk;

   ddr_to_rgb #(
      .RGB_WIDTH        (24),
      .FIFO_DEPTH       (4096),
      .DATA_COUNT_WIDTH (13),
      .BURST_LEN        (32),
      .FRAME_BASE_ADDR  (32'h100),
      .FRAME_PIXELS     (80)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .frame_start        (frame_start),
      .busy               (busy),
      .frame_done         (frame_done),
      .cmd_en             (cmd_en),
      .cmd_instr          (cmd_instr),
      .cmd_bl             (cmd_bl),
      .cmd_byte_addr      (cmd_byte_addr),
      .cmd_full           (cmd_full),
      .rd_en              (rd_en),
      .rd_data            (rd_data),
      .rd_empty           (rd_empty),
      .fifo_data_in       (fifo_data_in),
      .fifo_write_enable  (fifo_write_enable),
      .fifo_full          (fifo_full),
      .fifo_wr_data_count (fifo_wr_data_count)
`ifdef DDR_TO_RGB_STATUS_EN
      ,
      .err_overflow       (err_overflow),
      .frame_count        (frame_count),
      .stall_cycles       (stall_cycles)
`endif
   );

   // MCB read-data FIFO model plus observation queues.
   logic [31:0] mq[$];
   logic [23:0] wq[$];
   logic [35:0] cq[$];
   int          mcb_cnt = 0;
   logic [31:0] head = '0;
   logic        mask_empty = 1'b0;
   logic        auto_fill = 1'b1;
   logic        toggle_mode = 1'b0;
   int unsigned gen_idx = 0;
   int          n_pop = 0;
   int          done_cnt = 0;
   int          lat_err = 0;
   logic        prev_pop = 1'b0;
   logic [31:0] prev_word = '0;
   int          n_cmp = 0;
   int          n_bad = 0;

   assign rd_empty = (mcb_cnt == 0) || mask_empty;
   assign rd_data  = head;

   function automatic logic [31:0] word_of(int unsigned k);
      return {8'hC3, 24'(k * 32'h0001_0307 + 32'h00AB_CD01)};
   endfunction

   function automatic logic [35:0] get_cmd(int i);
      if (i < cq.size()) return cq[i];
      return '1;
   endfunction

   function automatic logic [23:0] get_wr(int i);
      if (i < wq.size()) return wq[i];
      return '1;
   endfunction

   function automatic logic [23:0] pix_of(int unsigned k);
      logic [31:0] w;
      w = word_of(k);
      return w[23:0];
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
      end
   endtask

   task automatic sync_model();
      mcb_cnt = mq.size();
      head    = (mq.size() > 0) ? mq[0] : 32'h0;
   endtask

   task automatic tick();
      logic        pop_now, cmd_now;
      logic [5:0]  bl;
      logic [29:0] a;
      logic [31:0] tmp;
      @(negedge clk);
      pop_now = rd_en;
      cmd_now = cmd_en;
      bl      = cmd_bl;
      a       = cmd_byte_addr;
      if (fifo_write_enable) wq.push_back(fifo_data_in);
      if (fifo_write_enable !== prev_pop) lat_err++;
      else if (prev_pop && fifo_data_in !== prev_word[23:0]) lat_err++;
      prev_pop  = rd_en && busy;
      prev_word = rd_data;
      if (frame_done) done_cnt++;
      if (cmd_now) cq.push_back({a, bl});
      @(posedge clk);
      #1;
      if (pop_now && mq.size() > 0) begin
         tmp = mq.pop_front();
         n_pop++;
      end
      if (cmd_now && auto_fill)
         for (int i = 0; i <= int'(bl); i++) begin
            mq.push_back(word_of(gen_idx));
            gen_idx++;
         end
      if (toggle_mode) mask_empty = ~mask_empty;
      sync_model();
   endtask

   task automatic run_until_done(input string tag, input int budget);
      int start, n;
      start = done_cnt;
      n = 0;
      while (done_cnt == start && n < budget) begin
         tick();
         n++;
      end
      repeat (3) tick();
      check({tag, "_done_pulses"}, 64'(done_cnt - start), 64'd1);
   endtask

   initial begin
      int unsigned base;
      int          n, p0, w0;

      rst = 1'b1; frame_start = 1'b0; cmd_full = 1'b0; fifo_full = 1'b0;
      fifo_wr_data_count = '0;
      sync_model();
      repeat (3) tick();

      // Reset state
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_cmd_en", 64'(cmd_en), 64'd0);
      check("rst_cmd_instr", 64'(cmd_instr), 64'd1);
      check("rst_cmd_bl", 64'(cmd_bl), 64'd0);
      check("rst_cmd_addr", 64'(cmd_byte_addr), 64'd0);
      check("rst_rd_en", 64'(rd_en), 64'd0);
      check("rst_wr_en", 64'(fifo_write_enable), 64'd0);
      check("rst_wr_data", 64'(fifo_data_in), 64'd0);
      check("rst_frame_done", 64'(frame_done), 64'd0);
      rst = 1'b0;
      tick();

      // Test 1: full frame, three bursts, in-order pixels
      wq.delete(); cq.delete();
      base = gen_idx;
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      check("t1_busy", 64'(busy), 64'd1);
      run_until_done("t1", 2000);
      check("t1_ncmd", 64'(cq.size()), 64'd3);
      check("t1_cmd0", 64'(get_cmd(0)), 64'({30'h100, 6'd31}));
      check("t1_cmd1", 64'(get_cmd(1)), 64'({30'h180, 6'd31}));
      check("t1_cmd2", 64'(get_cmd(2)), 64'({30'h200, 6'd15}));
      check("t1_nwr", 64'(wq.size()), 64'd80);
      for (int i = 0; i < 80; i++) check("t1_pix", 64'(get_wr(i)), 64'(pix_of(base + i)));
      check("t1_busy_end", 64'(busy), 64'd0);

      // Test 2: insufficient FIFO space holds the command
      wq.delete(); cq.delete();
      fifo_wr_data_count = 13'd4064;
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      repeat (8) tick();
      check("t2_hold_ncmd", 64'(cq.size()), 64'd0);
      check("t2_hold_busy", 64'(busy), 64'd1);
      fifo_wr_data_count = 13'd4060;
      tick();
      check("t2_pre_ncmd", 64'(cq.size()), 64'd0);
      tick();
      check("t2_rel_ncmd", 64'(cq.size()), 64'd1);
      check("t2_rel_cmd", 64'(get_cmd(0)), 64'({30'h100, 6'd31}));
      fifo_wr_data_count = '0;
      run_until_done("t2", 2000);
      check("t2_nwr", 64'(wq.size()), 64'd80);
      check("t2_ncmd", 64'(cq.size()), 64'd3);

      // Test 3: cmd_full back-pressure, single-cycle cmd_en on release
      cq.delete();
      cmd_full = 1'b1;
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      repeat (10) tick();
      check("t3_full_ncmd", 64'(cq.size()), 64'd0);
      cmd_full = 1'b0;
      tick(); tick();
      check("t3_rel_ncmd", 64'(cq.size()), 64'd1);
      tick();
      check("t3_one_cycle", 64'(cq.size()), 64'd1);
      run_until_done("t3", 2000);
      check("t3_ncmd", 64'(cq.size()), 64'd3);

      // Test 4: rd_empty toggling every cycle during the frame
      wq.delete();
      base = gen_idx;
      p0 = n_pop;
      toggle_mode = 1'b1;
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      run_until_done("t4", 4000);
      toggle_mode = 1'b0; mask_empty = 1'b0;
      check("t4_nwr", 64'(wq.size()), 64'd80);
      check("t4_npop", 64'(n_pop - p0), 64'd80);
      check("t4_mcb_left", 64'(mq.size()), 64'd0);
      check("t4_pix0", 64'(get_wr(0)), 64'(pix_of(base)));
      check("t4_pix41", 64'(get_wr(41)), 64'(pix_of(base + 41)));
      check("t4_pix79", 64'(get_wr(79)), 64'(pix_of(base + 79)));
      check("t4_latency", 64'(lat_err), 64'd0);

      // Test 5: reset after the 10th beat with 3 stale words left
      auto_fill = 1'b0;
      wq.delete(); cq.delete();
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      n = 0;
      while (cq.size() == 0 && n < 50) begin tick(); n++; end
      check("t5_cmd_seen", 64'(cq.size()), 64'd1);
      for (int i = 0; i < 13; i++) begin
         mq.push_back(word_of(gen_idx));
         gen_idx++;
      end
      sync_model();
      p0 = n_pop;
      n = 0;
      while (n_pop - p0 < 10 && n < 100) begin tick(); n++; end
      rst = 1'b1;
      tick();
      check("t5_rst_busy", 64'(busy), 64'd0);
      check("t5_rst_cmd_en", 64'(cmd_en), 64'd0);
      check("t5_rst_rd_en", 64'(rd_en), 64'd0);
      check("t5_rst_wr_en", 64'(fifo_write_enable), 64'd0);
      check("t5_rst_wr_data", 64'(fifo_data_in), 64'd0);
      check("t5_rst_done", 64'(frame_done), 64'd0);
      check("t5_nwr_before", 64'(wq.size()), 64'd10);
      tick();
      check("t5_stale_kept", 64'(mq.size()), 64'd3);
      rst = 1'b0;
      auto_fill = 1'b1;
      w0 = wq.size();
      frame_start = 1'b1;
      repeat (3) tick();
      check("t5_ignored", 64'(busy), 64'd0);
      check("t5_flushed", 64'(mq.size()), 64'd0);
      check("t5_flush_nowr", 64'(wq.size() - w0), 64'd0);
      tick();
      check("t5_accepted", 64'(busy), 64'd1);
      frame_start = 1'b0;
      run_until_done("t5", 2000);
      check("t5_nwr", 64'(wq.size() - w0), 64'd80);

`ifdef DDR_TO_RGB_STATUS_EN
      // Status: overflow flag and frame/stall counters
      check("st_err_clear", 64'(err_overflow), 64'd0);
      check("st_fc1", 64'(frame_count), 64'd1);
      fifo_full = 1'b1;
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      run_until_done("st", 2000);
      fifo_full = 1'b0;
      check("st_err_set", 64'(err_overflow), 64'd1);
      check("st_stall", 64'(stall_cycles), 64'd3);
      repeat (3) tick();
      check("st_err_sticky", 64'(err_overflow), 64'd1);
      check("st_fc2", 64'(frame_count), 64'd2);
`endif

      check("latency_align", 64'(lat_err), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
